melody_sequencer: RTL and testbench

Score player that sits directly upstream of the buzzer tone generator / 7-segment note display stage. It steps through a score ROM of (note code, duration) entries on a tempo tick and drives the 8-bit note code that the tone stage maps to a divider preload and shows on the display. It adds start/stop/pause/loop control, a silent articulation gap between notes, and end-of-score detection.

---
 rtl/melody_pkg.sv | 33 +++
 rtl/melody_rom.sv | 52 +++++
 rtl/melody_sequencer.sv | 160 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared types, note codes and score entry layout for the melody sequencer
//
// Purpose: sequencer state enum, 8-bit note code constants ({high[1:0],mid[2:0],low[2:0]}),
//          score ROM entry field widths and an entry packing helper.
// Ports:   none (package).
package melody_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int CODE_W  = 8;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = CODE_W + DUR_W;

  localparam logic [CODE_W-1:0] REST = 8'h00;
  localparam logic [CODE_W-1:0] L1 = 8'h01, L2 = 8'h02, L3 = 8'h03, L4 = 8'h04;
  localparam logic [CODE_W-1:0] L5 = 8'h05, L6 = 8'h06, L7 = 8'h07;
  localparam logic [CODE_W-1:0] M1 = 8'h08, M2 = 8'h10, M3 = 8'h18, M4 = 8'h20;
  localparam logic [CODE_W-1:0] M5 = 8'h28, M6 = 8'h30, M7 = 8'h38;
  localparam logic [CODE_W-1:0] H1 = 8'h40, H2 = 8'h80, H3 = 8'hC0;

  // Entry layout is {code, dur}; dur == 0 marks the end of the score.
  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [CODE_W-1:0] code,
                                                  input logic [DUR_W-1:0]  dur);
    return {code, dur};
  endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - combinational score ROM holding the production tune and a short test score
//
// Purpose: returns the {code, dur} entry at addr; unlisted addresses read as end marker.
// Ports:   addr  - ROM address ($clog2(SCORE_LEN) bits)
//          entry - {code[7:0], dur[3:0]}
module melody_rom
  import melody_pkg::*;
#(
  parameter int SCORE_LEN = 32,
  parameter int SCORE_SEL = 0
) (
  input  logic [$clog2(SCORE_LEN)-1:0] addr,
  output logic [ENTRY_W-1:0]           entry
);

  always_comb begin
    entry = mk_entry(REST, 4'd0);
    if (SCORE_SEL == 1) begin
      case (int'(addr))
        0:       entry = mk_entry(M1, 4'd2);
        1:       entry = mk_entry(M3, 4'd1);
        2:       entry = mk_entry(REST, 4'd1);
        default: entry = mk_entry(REST, 4'd0);
      endcase
    end else begin
      case (int'(addr))
        0:       entry = mk_entry(M1, 4'd1);
        1:       entry = mk_entry(M1, 4'd1);
        2:       entry = mk_entry(M5, 4'd1);
        3:       entry = mk_entry(M5, 4'd1);
        4:       entry = mk_entry(M6, 4'd1);
        5:       entry = mk_entry(M6, 4'd1);
        6:       entry = mk_entry(M5, 4'd2);
        7:       entry = mk_entry(M4, 4'd1);
        8:       entry = mk_entry(M4, 4'd1);
        9:       entry = mk_entry(M3, 4'd1);
        10:      entry = mk_entry(M3, 4'd1);
        11:      entry = mk_entry(M2, 4'd1);
        12:      entry = mk_entry(M2, 4'd1);
        13:      entry = mk_entry(M1, 4'd2);
        14:      entry = mk_entry(REST, 4'd1);
        15:      entry = mk_entry(L5, 4'd1);
        16:      entry = mk_entry(M7, 4'd1);
        17:      entry = mk_entry(H1, 4'd2);
        18:      entry = mk_entry(H2, 4'd1);
        19:      entry = mk_entry(H3, 4'd2);
        default: entry = mk_entry(REST, 4'd0);
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - score player stepping a note ROM on a tempo tick with start/stop/pause/loop
//
// Purpose: plays {code,dur} entries, each as dur*TICK_DIV cycles of tone plus GAP_CYC cycles of silence.
// Ports:   clk, rst_n (sync active-low), start/stop (pulses), pause/loop_en (levels)
//          note_code - note to sound (0 = silence); gate - non-rest note sounding
//          note_idx  - current ROM address; busy - in LOAD/PLAY/GAP; done - pulse on entering DONE
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int TICK_DIV  = 10000000,
  parameter int GAP_CYC   = 500000,
  parameter int SCORE_LEN = 32,
  parameter int SCORE_SEL = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         pause,
  input  logic                         loop_en,
  output logic [CODE_W-1:0]            note_code,
  output logic                         gate,
  output logic [$clog2(SCORE_LEN)-1:0] note_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = $clog2(SCORE_LEN);
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t              state, state_n;
  logic [AW-1:0]       addr, addr_n;
  logic                wrapped, wrapped_n;   // addr rolled over from the last entry
  logic [CODE_W-1:0]   code_q, code_n;
  logic [DUR_W-1:0]    remaining, rem_n;
  logic [TW-1:0]       tick_cnt, tick_n;
  logic [GW-1:0]       gap_cnt, gap_n;
  logic                hold;
  logic [ENTRY_W-1:0]  rom_entry;
  logic [CODE_W-1:0]   rom_code;
  logic [DUR_W-1:0]    rom_dur;
  logic                rom_end;
  logic [CODE_W-1:0]   code_d;

  melody_rom #(.SCORE_LEN(SCORE_LEN), .SCORE_SEL(SCORE_SEL)) u_rom (
    .addr  (addr),
    .entry (rom_entry)
  );

  assign rom_code = rom_entry[ENTRY_W-1:DUR_W];
  assign rom_dur  = rom_entry[DUR_W-1:0];
  assign rom_end  = (rom_dur == '0) || wrapped;
  assign note_idx = addr;

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    wrapped_n = wrapped;
    code_n    = code_q;
    rem_n     = remaining;
    tick_n    = tick_cnt;
    gap_n     = gap_cnt;
    hold      = 1'b0;
    if (stop) begin
      state_n   = ST_IDLE;
      addr_n    = '0;
      wrapped_n = 1'b0;
      code_n    = REST;
      rem_n     = '0;
      tick_n    = '0;
      gap_n     = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_n   = ST_LOAD;
            addr_n    = '0;
            wrapped_n = 1'b0;
          end
        end
        ST_LOAD: begin
          if (rom_end) begin
            // An end marker at entry 0 can never loop: it would spin in LOAD forever.
            if (loop_en && (addr != '0 || wrapped)) begin
              addr_n    = '0;
              wrapped_n = 1'b0;
            end else begin
              state_n = ST_DONE;
            end
          end else begin
            code_n  = rom_code;
            rem_n   = rom_dur;
            tick_n  = '0;
            state_n = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (pause) begin
            hold = 1'b1;
          end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_n = '0;
            rem_n  = remaining - 1'b1;
            if (remaining == DUR_W'(1)) begin
              gap_n   = '0;
              state_n = ST_GAP;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (pause) begin
            hold = 1'b1;
          end else if (gap_cnt == GW'(GAP_CYC - 1)) begin
            gap_n   = '0;
            addr_n  = addr + 1'b1;
            state_n = ST_LOAD;
            if (addr == AW'(SCORE_LEN - 1)) wrapped_n = 1'b1;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  assign code_d = (state_n == ST_PLAY && !hold) ? code_n : REST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      wrapped   <= 1'b0;
      code_q    <= REST;
      remaining <= '0;
      tick_cnt  <= '0;
      gap_cnt   <= '0;
      note_code <= REST;
      gate      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      wrapped   <= wrapped_n;
      code_q    <= code_n;
      remaining <= rem_n;
      tick_cnt  <= tick_n;
      gap_cnt   <= gap_n;
      note_code <= code_d;
      gate      <= (code_d != REST);
      busy      <= (state_n == ST_LOAD) || (state_n == ST_PLAY) || (state_n == ST_GAP);
      done      <= (state_n == ST_DONE) && (state != ST_DONE);
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - directed self-checking bench for melody_sequencer on the test score
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] note_code;
  logic       gate;
  logic [4:0] note_idx;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hits = 0;
  int done_cnt = 0;

  melody_sequencer #(
    .TICK_DIV  (4),
    .GAP_CYC   (2),
    .SCORE_LEN (32),
    .SCORE_SEL (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .note_code (note_code),
    .gate      (gate),
    .note_idx  (note_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // start is high during cycle 0; returns in cycle 1
  task automatic kick();
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".note"}, 32'(note_code), 32'h0);
    chk({tag, ".gate"}, 32'(gate), 32'h0);
    chk({tag, ".idx"},  32'(note_idx), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".done"}, 32'(done), 32'h0);
  endtask

  // Hand-derived timeline of the test score with TICK_DIV=4, GAP_CYC=2
  function automatic logic [7:0] exp_note(input int c);
    if (c >= 2 && c <= 9) return 8'h08;
    if (c >= 13 && c <= 16) return 8'h18;
    return 8'h00;
  endfunction

  function automatic logic [4:0] exp_idx(input int c);
    if (c <= 11) return 5'd0;
    if (c <= 18) return 5'd1;
    if (c <= 25) return 5'd2;
    return 5'd3;
  endfunction

  initial begin
    // 1: reset held 3 cycles with start high; start must be ignored
    start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk_quiet("rst_hold");
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_quiet("rst_rel");
    tick();
    chk_quiet("idle");

    // 2: full run without loop
    kick();
    while (cyc <= 28) begin
      chk($sformatf("run.note@%0d", cyc), 32'(note_code), 32'(exp_note(cyc)));
      chk($sformatf("run.gate@%0d", cyc), 32'(gate), 32'(exp_note(cyc) != 8'h00));
      chk($sformatf("run.idx@%0d", cyc),  32'(note_idx), 32'(exp_idx(cyc)));
      chk($sformatf("run.busy@%0d", cyc), 32'(busy), 32'(cyc <= 26));
      chk($sformatf("run.done@%0d", cyc), 32'(done), 32'(cyc == 27));
      tick();
    end

    // 3: loop over the end marker
    loop_en = 1'b1;
    kick();
    done_cnt = 0;
    while (cyc < 27) begin
      if (done) done_cnt++;
      tick();
    end
    chk("loop.idx@27", 32'(note_idx), 32'h0);
    chk("loop.busy@27", 32'(busy), 32'h1);
    tick();
    chk("loop.note@28", 32'(note_code), 32'h08);
    chk("loop.gate@28", 32'(gate), 32'h1);
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("loop.no_done", 32'(done_cnt), 32'h0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 1'b0;
    chk_quiet("loop.stop");

    // 4: pause for 5 cycles inside the first note
    kick();
    hits = 0;
    while (cyc <= 17) begin
      if (note_code == 8'h08) hits++;
      if (cyc == 7) begin
        chk("pause.note@7", 32'(note_code), 32'h0);
        chk("pause.gate@7", 32'(gate), 32'h0);
        chk("pause.busy@7", 32'(busy), 32'h1);
      end
      if (cyc == 10) chk("pause.resume@10", 32'(note_code), 32'h08);
      if (cyc == 14) chk("pause.last@14", 32'(note_code), 32'h08);
      if (cyc == 15) chk("pause.gap@15", 32'(note_code), 32'h0);
      if (cyc == 17) chk("pause.idx@17", 32'(note_idx), 32'h1);
      pause = (cyc >= 4 && cyc <= 8);
      tick();
    end
    pause = 1'b0;
    chk("pause.count", 32'(hits), 32'd8);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // 5: stop and start together during PLAY
    kick();
    while (cyc < 4) tick();
    chk("ss.pre", 32'(note_code), 32'h08);
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    chk_quiet("ss.stop");
    tick();
    chk_quiet("ss.stay");
    kick();
    chk("ss.busy@1", 32'(busy), 32'h1);
    tick();
    chk("ss.note@2", 32'(note_code), 32'h08);
    chk("ss.idx@2", 32'(note_idx), 32'h0);

    // 6: reset during the gap of entry 1
    while (cyc < 17) tick();
    chk("rg.idx@17", 32'(note_idx), 32'h1);
    chk("rg.busy@17", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_quiet("rg.reset");
    kick();
    chk("rg.busy@1", 32'(busy), 32'h1);
    tick();
    chk("rg.note@2", 32'(note_code), 32'h08);
    chk("rg.idx@2", 32'(note_idx), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
